// File: rtl/cv_drive_seq_pkg.sv
// Shared types and helpers for the PMOS drive-cell sequencer.
package cv_drive_seq_pkg;

  typedef enum logic [1:0] {StIdle, StStep, StDwell} state_e;

  // Legs interleave across instances: leg j -> instance j % num_inst, gate bit j / num_inst.
  function automatic int unsigned leg_bit(input int unsigned j, input int unsigned num_inst,
                                          input int unsigned num_bits);
    return (j % num_inst) * num_bits + (j / num_inst);
  endfunction

  function automatic int unsigned cw_calc(input int unsigned num_legs);
    return $clog2(num_legs + 1);
  endfunction

endpackage

// File: rtl/cv_drive_seq_if.sv
// Request/status bundle between configuration logic (master) and the sequencer (slave).
interface cv_drive_seq_if #(
  parameter int unsigned NUM_INST = 2,
  parameter int unsigned NUM_BITS = 2
);
  import cv_drive_seq_pkg::*;

  localparam int unsigned NUM_LEGS = NUM_INST * NUM_BITS;
  localparam int unsigned CW       = cw_calc(NUM_LEGS);

  logic                req_valid;
  logic                req_ready;
  logic [CW-1:0]       req_code;
  logic [NUM_LEGS-1:0] ctrl;
  logic [CW-1:0]       level;
  logic                busy;
  logic                done;

  modport master (
    output req_valid, req_code,
    input  req_ready, ctrl, level, busy, done
  );

  modport slave (
    input  req_valid, req_code,
    output req_ready, ctrl, level, busy, done
  );

endinterface

// File: rtl/cv_drive_seq_timer.sv
// Loadable dwell down-counter; expire is high on the last dwell cycle.
module cv_drive_seq_timer #(
  parameter int unsigned Cycles = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned  TW      = (Cycles > 2) ? $clog2(Cycles) : 1;
  localparam logic [TW-1:0] LoadVal = TW'((Cycles > 1) ? Cycles - 1 : 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LoadVal;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == TW'(1));

endmodule

// File: rtl/cv_drive_seq.sv
// Steps active-low PMOS gate buses one leg at a time toward a requested leg count.
// Optional CV_DRIVE_SEQ_ABORT_EN adds an abort input that drops all legs at once.
module cv_drive_seq #(
  parameter int unsigned NUM_INST = 2,
  parameter int unsigned NUM_BITS = 2,
  parameter int unsigned STEP_CYC = 4
) (
  input logic clk,
  input logic rst,
`ifdef CV_DRIVE_SEQ_ABORT_EN
  input logic abort,
`endif
  cv_drive_seq_if.slave bus
);
  import cv_drive_seq_pkg::*;

  localparam int unsigned         NUM_LEGS = NUM_INST * NUM_BITS;
  localparam int unsigned         CW       = cw_calc(NUM_LEGS);
  localparam logic [CW-1:0]       MaxLvl   = CW'(NUM_LEGS);
  localparam logic [NUM_LEGS-1:0] LegOne   = NUM_LEGS'(1);

  state_e              state_q;
  logic [CW-1:0]       level_q;
  logic [CW-1:0]       target_q;
  logic [NUM_LEGS-1:0] ctrl_q;
  logic                done_q;

  logic [CW-1:0]       level_nxt;
  logic [NUM_LEGS-1:0] ctrl_nxt;
  logic [CW-1:0]       code_clamped;
  logic                tmr_load;
  logic                tmr_expire;

  // Gate pattern for a given leg count: legs 0..lvl-1 pulled low.
  function automatic logic [NUM_LEGS-1:0] ctrl_of(input logic [CW-1:0] lvl);
    logic [NUM_LEGS-1:0] c;
    c = '1;
    for (int j = 0; j < int'(NUM_LEGS); j++) begin
      if (j < int'(lvl)) c = c & ~(LegOne << leg_bit(j, NUM_INST, NUM_BITS));
    end
    return c;
  endfunction

  assign code_clamped = (bus.req_code > MaxLvl) ? MaxLvl : bus.req_code;
  assign level_nxt    = (target_q > level_q) ? level_q + 1'b1 : level_q - 1'b1;
  assign ctrl_nxt     = ctrl_of(level_nxt);
  assign tmr_load     = (state_q == StStep) && (level_q != target_q);

  cv_drive_seq_timer #(
    .Cycles(STEP_CYC)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .en    (state_q == StDwell),
    .expire(tmr_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      level_q  <= '0;
      target_q <= '0;
      ctrl_q   <= '1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            target_q <= code_clamped;
            state_q  <= StStep;
          end
        end
        StStep: begin
          if (level_q == target_q) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            level_q <= level_nxt;
            ctrl_q  <= ctrl_nxt;
            state_q <= (STEP_CYC == 1) ? StStep : StDwell;
          end
        end
        StDwell: begin
          if (tmr_expire) state_q <= StStep;
        end
        default: state_q <= StIdle;
      endcase
`ifdef CV_DRIVE_SEQ_ABORT_EN
      // Placed last so it overrides any leg change decided above.
      if (abort && (state_q != StIdle)) begin
        ctrl_q  <= '1;
        level_q <= '0;
        done_q  <= 1'b1;
        state_q <= StIdle;
      end
`endif
    end
  end

  assign bus.ctrl      = ctrl_q;
  assign bus.level     = level_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.req_ready = (state_q == StIdle);

endmodule

// File: tb/tb_cv_drive_seq.sv
// Directed plus random ramps against a schedule-based model of the drive sequencer.
module tb_cv_drive_seq;

  localparam int unsigned NI = 2;
  localparam int unsigned NB = 2;
  localparam int unsigned SC = 4;
  localparam int unsigned NL = NI * NB;

  logic clk = 1'b0;
  logic rst;
`ifdef CV_DRIVE_SEQ_ABORT_EN
  logic abort;
`endif

  cv_drive_seq_if #(.NUM_INST(NI), .NUM_BITS(NB)) bus ();

  cv_drive_seq #(
    .NUM_INST(NI),
    .NUM_BITS(NB),
    .STEP_CYC(SC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef CV_DRIVE_SEQ_ABORT_EN
    .abort(abort),
`endif
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int mlvl  = 0;

  // Expected gate pattern: leg j on means instance j%NI, bit j/NI is low.
  function automatic logic [31:0] exp_ctrl(input int lvl);
    logic [NL-1:0] c;
    c = '1;
    for (int j = 0; j < lvl; j++) c[(j % NI) * NB + (j / NI)] = 1'b0;
    return 32'(c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, ".ctrl"},  32'(bus.ctrl), 32'hf);
    chk({tag, ".level"}, 32'(bus.level), 32'd0);
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, ".busy"},  32'(bus.busy), 32'd0);
    chk({tag, ".done"},  32'(bus.done), 32'd0);
  endtask

  task automatic present(input int code);
    chk("accept.ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_code  = 3'(code);
  endtask

  // Accept happens at the next edge; then every cycle is checked against the schedule
  // "leg change at t+1+k*SC, done at t+1+N*SC". Returns at the done cycle.
  task automatic follow(input int code, input bit hold);
    int tgt, n, dir, k_end, exp_lvl;
    tgt   = (code > int'(NL)) ? int'(NL) : code;
    n     = (tgt > mlvl) ? tgt - mlvl : mlvl - tgt;
    dir   = (tgt > mlvl) ? 1 : -1;
    k_end = 1 + n * int'(SC);
    tick();
    if (hold) bus.req_code = 3'($urandom_range(0, 7));
    else bus.req_valid = 1'b0;
    chk("ramp.busy0", 32'(bus.busy), 32'd1);
    chk("ramp.ready0", 32'(bus.req_ready), 32'd0);
    for (int k = 1; k <= k_end; k++) begin
      if (k == k_end) bus.req_valid = 1'b0;
      tick();
      exp_lvl = mlvl + dir * (((k - 1) / int'(SC) + 1 < n) ? (k - 1) / int'(SC) + 1 : n);
      chk("ramp.level", 32'(bus.level), 32'(exp_lvl));
      chk("ramp.ctrl",  32'(bus.ctrl), exp_ctrl(exp_lvl));
      chk("ramp.done",  32'(bus.done), 32'(k == k_end));
      chk("ramp.busy",  32'(bus.busy), 32'(k != k_end));
    end
    mlvl = tgt;
  endtask

  task automatic run_req(input int code);
    present(code);
    follow(code, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_code  = '0;
`ifdef CV_DRIVE_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    #2;
    chk_idle_reset("reset");
    tick();
    rst = 1'b0;
    tick();
    chk_idle_reset("post_reset");

    // Ramp up 0 -> 3 with literal checks from the expected waveform.
    run_req(3);
    chk("up.final_ctrl", 32'(bus.ctrl), 32'b1000);
    chk("up.final_lvl",  32'(bus.level), 32'd3);

    // Ramp down 3 -> 1 while req_valid stays high; nothing extra may be accepted.
    tick();
    present(1);
    follow(1, 1'b1);
    chk("down.final_ctrl", 32'(bus.ctrl), 32'b1110);
    tick();
    chk("down.no_accept", 32'(bus.busy), 32'd0);

    // Clamp, then a no-op request.
    run_req(7);
    chk("clamp.ctrl", 32'(bus.ctrl), 32'b0000);
    tick();
    run_req(4);
    chk("noop.ctrl", 32'(bus.ctrl), 32'b0000);

    // Back-to-back: present the next request while done is high.
    run_req(2);
    chk("b2b.done_high", 32'(bus.done), 32'd1);
    run_req(0);
    run_req(1);

    // Random targets.
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 1) == 1) tick();
      run_req(int'($urandom_range(0, 7)));
    end

    // Asynchronous reset mid-ramp at level 2.
    run_req(0);
    tick();
    present(4);
    tick();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("midreset.pre_level", 32'(bus.level), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_idle_reset("midreset");
    tick();
    rst  = 1'b0;
    mlvl = 0;
    tick();
    chk_idle_reset("midreset.after");

`ifdef CV_DRIVE_SEQ_ABORT_EN
    // Abort during a 0 -> 4 ramp: driven after edge t+6, taking effect at t+7.
    present(4);
    tick();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("abort.pre_level", 32'(bus.level), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort.ctrl",  32'(bus.ctrl), 32'hf);
    chk("abort.level", 32'(bus.level), 32'd0);
    chk("abort.done",  32'(bus.done), 32'd1);
    chk("abort.ready", 32'(bus.req_ready), 32'd1);
    mlvl = 0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort.idle_ignored", 32'(bus.done), 32'd0);
    run_req(1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
